// File: rtl/order_queue.sv
// order_queue: first-word-fall-through FIFO for order tags.
//
// The head entry is always visible on outData with no read latency. A pop
// moves outData on to the next entry at the following clock edge.
//
// Ports
//   clock     rising-edge clock
//   reset     asynchronous, active-high; discards all queued entries
//   inData    tag to push
//   new_data  push request; ignored while full
//   out_data  pop request; ignored while empty
//   outData   head entry, or 0 while empty
//   full      DEPTH entries stored
//   empty     no entries stored
module order_queue #(
  parameter int WIDTH        = 5,
  parameter int DEPTH        = 32,
  parameter int ADDRESSWIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] inData,
  input  logic             new_data,
  input  logic             out_data,
  output logic [WIDTH-1:0] outData,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = ADDRESSWIDTH - 1;

  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [ADDRESSWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESSWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                    push, pop;

  // Pointers carry one extra wrap bit. Equal pointers mean empty. Equal
  // index bits with different wrap bits mean the writer is a full lap ahead.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
            (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  end

  // The flags gate both requests. A push and a pop on an empty queue therefore
  // store the entry without popping it, and on a full queue they pop only.
  always_comb begin
    push     = new_data && !full;
    pop      = out_data && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDRESSWIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDRESSWIDTH'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset. Stale contents are never visible, because outData is
  // forced to 0 while empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= inData;
  end

  always_comb begin
    outData = empty ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_order_queue.sv
module tb_order_queue;

  localparam int WIDTH = 5;
  localparam int DEPTH = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] inData = '0;
  logic             new_data = 1'b0;
  logic             out_data = 1'b0;
  logic [WIDTH-1:0] outData;
  logic             full, empty;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] exp_q[$];

  order_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRESSWIDTH(6)) dut (
    .clock   (clock),
    .reset   (reset),
    .inData  (inData),
    .new_data(new_data),
    .out_data(out_data),
    .outData (outData),
    .full    (full),
    .empty   (empty)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs are compared with the scoreboard head and its occupancy.
  task automatic check_outputs(input string tag);
    int sz;
    sz = exp_q.size();
    chk_eq({tag, "_empty"}, int'(empty), (sz == 0) ? 1 : 0);
    chk_eq({tag, "_full"}, int'(full), (sz == DEPTH) ? 1 : 0);
    chk_eq({tag, "_data"}, int'(outData), (sz == 0) ? 0 : int'(exp_q[0]));
  endtask

  // Apply one cycle of requests. Outputs are checked at the negedge before the
  // edge, and the scoreboard is updated with the requests the model accepts.
  task automatic cycle(input string tag, input logic nd, input logic od,
                       input logic [WIDTH-1:0] d);
    bit do_push, do_pop;
    new_data = nd;
    out_data = od;
    inData   = d;
    check_outputs(tag);
    do_pop  = od && (exp_q.size() > 0);
    do_push = nd && (exp_q.size() < DEPTH);
    @(posedge clock);
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(d);
    @(negedge clock);
    new_data = 1'b0;
    out_data = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk_eq({tag, "_empty"}, int'(empty), 1);
    chk_eq({tag, "_full"}, int'(full), 0);
    chk_eq({tag, "_data"}, int'(outData), 0);
    @(negedge clock);
    reset = 1'b0;
    check_outputs({tag, "_rel"});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clock);
    @(negedge clock);
    chk_eq("rst_empty", int'(empty), 1);
    chk_eq("rst_full", int'(full), 0);
    chk_eq("rst_data", int'(outData), 0);
    reset = 1'b0;
    @(negedge clock);

    // Reset while entries are queued.
    for (int i = 0; i < 3; i++) cycle("pre", 1'b1, 1'b0, WIDTH'(i + 7));
    chk_eq("pre_empty", int'(empty), 0);
    async_reset("midrst");

    // Fill 0..41; entries 32..41 must be dropped.
    for (int i = 0; i < 42; i++) cycle("fill", 1'b1, 1'b0, WIDTH'(i));
    chk_eq("fill_full", int'(full), 1);
    chk_eq("fill_head", int'(outData), 0);

    // Drain 42 times; the last 10 pops hit an empty queue.
    for (int i = 0; i < 42; i++) begin
      if (i < 32) chk_eq("drain_order", int'(outData), i);
      cycle("drain", 1'b0, 1'b1, '0);
    end
    chk_eq("drain_empty", int'(empty), 1);
    chk_eq("drain_data", int'(outData), 0);

    // Push and pop together on an empty queue.
    cycle("sim_first", 1'b1, 1'b1, 5'd4);
    chk_eq("sim_first_data", int'(outData), 4);
    for (int i = 1; i < 132; i++) cycle("sim", 1'b1, 1'b1, 5'd4);
    chk_eq("sim_occ_data", int'(outData), 4);
    cycle("sim_drain", 1'b0, 1'b1, '0);
    chk_eq("sim_drain_empty", int'(empty), 1);

    // Fill to full, then push and pop together.
    for (int i = 0; i < DEPTH; i++) cycle("full2", 1'b1, 1'b0, WIDTH'(31 - i));
    chk_eq("full2_full", int'(full), 1);
    cycle("fullsim", 1'b1, 1'b1, 5'd31);
    chk_eq("fullsim_full", int'(full), 0);
    chk_eq("fullsim_occ", exp_q.size(), DEPTH - 1);
    chk_eq("fullsim_head", int'(outData), 30);
    while (exp_q.size() > 0) cycle("full2_drain", 1'b0, 1'b1, '0);

    // Interleaved bursts that carry both pointers across the wrap points.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) cycle("wrap_push", 1'b1, 1'b0, WIDTH'(r * 20 + i + 3));
      for (int i = 0; i < 20; i++) begin
        chk_eq("wrap_order", int'(outData), (r * 20 + i + 3) % 32);
        cycle("wrap_pop", 1'b0, 1'b1, '0);
      end
    end

    // Random mix of requests.
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            WIDTH'($urandom));
    async_reset("endrst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
